// File: rtl/color_sensor_pkg.sv
// Shared encodings for the colour sensor scale/filter pins and the frequency-scale multipliers.
// Imported by both the colour reader and the sensor emulator.
package color_sensor_pkg;

  typedef enum logic [1:0] {
    FILT_RED   = 2'b00,
    FILT_BLUE  = 2'b01,
    FILT_CLEAR = 2'b10,
    FILT_GREEN = 2'b11
  } filt_e;

  typedef enum logic [1:0] {
    SCALE_OFF  = 2'b00,
    SCALE_2P   = 2'b01,
    SCALE_20P  = 2'b10,
    SCALE_100P = 2'b11
  } scale_e;

  localparam int MULT_W = 6;

  localparam logic [MULT_W-1:0] MULT_2P   = 6'd50;
  localparam logic [MULT_W-1:0] MULT_20P  = 6'd5;
  localparam logic [MULT_W-1:0] MULT_100P = 6'd1;

  // Lower output scale means a slower square wave, so the period multiplier grows.
  function automatic logic [MULT_W-1:0] scale_mult(input logic [1:0] s);
    case (s)
      SCALE_2P:   return MULT_2P;
      SCALE_20P:  return MULT_20P;
      SCALE_100P: return MULT_100P;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/color_sensor_halfper_gen.sv
// Half-period counter and toggle for the emulated sensor square wave.
// eff_hp is latched at every half-period start; a latched zero holds the output low.
module color_sensor_halfper_gen #(
  parameter int HP_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart,
  input  logic            idle,
  input  logic [HP_W-1:0] eff_hp,
  output logic            sensor_freq,
  output logic            rise_pulse
);

  logic [HP_W-1:0] cnt_p1;
  logic [HP_W-1:0] eff_p1;

  // Stage p1: counter, latched half-period and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1      <= '0;
      eff_p1      <= '0;
      sensor_freq <= 1'b0;
      rise_pulse  <= 1'b0;
    end else if (idle) begin
      cnt_p1      <= '0;
      sensor_freq <= 1'b0;
      rise_pulse  <= 1'b0;
    end else if (restart || eff_p1 == '0) begin
      cnt_p1      <= '0;
      eff_p1      <= eff_hp;
      sensor_freq <= 1'b0;
      rise_pulse  <= 1'b0;
    end else if (cnt_p1 == eff_p1 - HP_W'(1)) begin
      cnt_p1 <= '0;
      eff_p1 <= eff_hp;
      if (eff_hp == '0) begin
        sensor_freq <= 1'b0;
        rise_pulse  <= 1'b0;
      end else begin
        sensor_freq <= ~sensor_freq;
        rise_pulse  <= ~sensor_freq;
      end
    end else begin
      cnt_p1     <= cnt_p1 + HP_W'(1);
      rise_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/color_sensor_emulator.sv
// Emulates the colour sensor frequency output from the scale/filter/enable pins,
// with runtime-programmable full-scale half-periods per channel.
module color_sensor_emulator
  import color_sensor_pkg::*;
#(
  parameter int HP_W         = 24,
  parameter int DEF_RED_HP   = 500,
  parameter int DEF_BLUE_HP  = 700,
  parameter int DEF_CLEAR_HP = 200,
  parameter int DEF_GREEN_HP = 600
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      scale,
  input  logic [1:0]      filter,
  input  logic            enf,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_sel,
  input  logic [HP_W-1:0] cfg_hp,
  output logic            sensor_freq,
  output logic            rise_pulse
);

  localparam int PROD_W = HP_W + MULT_W;

  function automatic logic [HP_W-1:0] sat_hp(input logic [PROD_W-1:0] p);
    if (|p[PROD_W-1:HP_W]) return '1;
    return p[HP_W-1:0];
  endfunction

  logic [HP_W-1:0]   hp_q [4];
  logic [1:0]        filt_p1;
  logic [1:0]        scale_p1;
  logic              enf_p1;
  logic              first_p1;
  logic [HP_W-1:0]   hp_sel_p0;
  logic [PROD_W-1:0] prod_p0;
  logic [HP_W-1:0]   eff_hp_p0;
  logic              restart_p0;
  logic              idle_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_q[FILT_RED]   <= HP_W'(DEF_RED_HP);
      hp_q[FILT_BLUE]  <= HP_W'(DEF_BLUE_HP);
      hp_q[FILT_CLEAR] <= HP_W'(DEF_CLEAR_HP);
      hp_q[FILT_GREEN] <= HP_W'(DEF_GREEN_HP);
    end else if (cfg_we) begin
      hp_q[cfg_sel] <= cfg_hp;
    end
  end

  // first_p1 makes the first active cycle after reset behave as a selection change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_p1  <= '0;
      scale_p1 <= '0;
      enf_p1   <= 1'b0;
      first_p1 <= 1'b1;
    end else begin
      filt_p1  <= filter;
      scale_p1 <= scale;
      enf_p1   <= enf;
      first_p1 <= 1'b0;
    end
  end

  // Stage p0: a same-cycle write to the selected channel bypasses the register
  assign hp_sel_p0  = (cfg_we && cfg_sel == filter) ? cfg_hp : hp_q[filter];
  assign prod_p0    = PROD_W'(hp_sel_p0) * PROD_W'(scale_mult(scale));
  assign eff_hp_p0  = sat_hp(prod_p0);
  assign restart_p0 = first_p1 | (filter != filt_p1) | (scale != scale_p1) | (enf & ~enf_p1);
  assign idle_p0    = ~enf | (scale == SCALE_OFF);

  color_sensor_halfper_gen #(
    .HP_W(HP_W)
  ) u_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart_p0),
    .idle       (idle_p0),
    .eff_hp     (eff_hp_p0),
    .sensor_freq(sensor_freq),
    .rise_pulse (rise_pulse)
  );

endmodule

// File: tb/tb_color_sensor_emulator.sv
// Directed bench for color_sensor_emulator: per-cycle reference model plus literal timing checks.
module tb_color_sensor_emulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  scale = 2'b11;
  logic [1:0]  filter = 2'b00;
  logic        enf = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = 2'b00;
  logic [23:0] cfg_hp = '0;
  logic        sensor_freq;
  logic        rise_pulse;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  color_sensor_emulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scale      (scale),
    .filter     (filter),
    .enf        (enf),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_hp     (cfg_hp),
    .sensor_freq(sensor_freq),
    .rise_pulse (rise_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int mult_of(input logic [1:0] s);
    case (s)
      2'b01:   return 50;
      2'b10:   return 5;
      2'b11:   return 1;
      default: return 0;
    endcase
  endfunction

  // Reference model: half-period length = min(hp * mult, 2^24-1), counted down per clock
  int     m_hp [4];
  bit     m_freq, m_rise, m_first, m_pe;
  int     m_eff, m_left;
  logic [1:0] m_pf, m_ps;
  int     nh [4];
  longint prod;
  int     ce;
  bit     chg;

  always_comb begin
    nh = m_hp;
    if (cfg_we) nh[cfg_sel] = int'(cfg_hp);
    prod = longint'(nh[filter]) * longint'(mult_of(scale));
    ce   = (prod > 64'd16777215) ? 16777215 : int'(prod);
    chg  = m_first || (filter != m_pf) || (scale != m_ps) || (enf && !m_pe);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hp    <= '{500, 700, 200, 600};
      m_freq  <= 1'b0;
      m_rise  <= 1'b0;
      m_eff   <= 0;
      m_left  <= 0;
      m_first <= 1'b1;
      m_pf    <= 2'b00;
      m_ps    <= 2'b00;
      m_pe    <= 1'b0;
    end else begin
      if (!enf || scale == 2'b00) begin
        m_freq <= 1'b0;
        m_rise <= 1'b0;
      end else if (chg || m_eff == 0) begin
        m_freq <= 1'b0;
        m_rise <= 1'b0;
        m_eff  <= ce;
        m_left <= ce;
      end else if (m_left == 1) begin
        m_eff  <= ce;
        m_left <= ce;
        if (ce == 0) begin
          m_freq <= 1'b0;
          m_rise <= 1'b0;
        end else begin
          m_freq <= !m_freq;
          m_rise <= !m_freq;
        end
      end else begin
        m_left <= m_left - 1;
        m_rise <= 1'b0;
      end
      m_hp    <= nh;
      m_pf    <= filter;
      m_ps    <= scale;
      m_pe    <= enf;
      m_first <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_freq", int'(sensor_freq), int'(m_freq));
      chk("model_rise", int'(rise_pulse), int'(m_rise));
    end
  end

  task automatic wait_lvl(input logic lvl, input int maxc, output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sensor_freq !== lvl && n < maxc);
    if (sensor_freq !== lvl) chk("timeout_lvl", int'(sensor_freq), int'(lvl));
    t = cyc;
  endtask

  task automatic count_act(input int n, output int hi, output int rs);
    hi = 0;
    rs = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(sensor_freq);
      rs += int'(rise_pulse);
    end
  endtask

  initial begin
    int t0, t1, t2, t3, t4, hi, rs;
    repeat (3) @(negedge clk);
    chk("reset_freq", int'(sensor_freq), 0);
    chk("reset_rise", int'(rise_pulse), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Red, full scale
    enf = 1'b1; t0 = cyc + 1;
    wait_lvl(1'b1, 2000, t1);
    chk("red_first_rise", t1 - t0, 500);
    hi = 1;
    repeat (999) begin @(negedge clk); hi += int'(sensor_freq); end
    chk("red_duty_high", hi, 500);
    wait_lvl(1'b1, 2000, t2);
    chk("red_period", t2 - t1, 1000);

    // Scale 11 -> 10 during the high half
    repeat (100) @(negedge clk);
    scale = 2'b10; t0 = cyc + 1;
    @(negedge clk);
    chk("scale_chg_low", int'(sensor_freq), 0);
    wait_lvl(1'b1, 6000, t1);
    chk("x5_first_rise", t1 - t0, 2500);
    wait_lvl(1'b0, 6000, t2);
    chk("x5_high", t2 - t1, 2500);
    wait_lvl(1'b1, 6000, t3);
    chk("x5_period", t3 - t1, 5000);

    // Runtime write to the running channel
    scale = 2'b11; t0 = cyc + 1;
    wait_lvl(1'b1, 2000, t1);
    chk("back_x1_rise", t1 - t0, 500);
    repeat (50) @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 2'b00; cfg_hp = 24'd100;
    @(negedge clk); cfg_we = 1'b0;
    wait_lvl(1'b0, 2000, t2);
    chk("wr_old_half", t2 - t1, 500);
    wait_lvl(1'b1, 2000, t3);
    chk("wr_new_low", t3 - t2, 100);
    wait_lvl(1'b0, 2000, t4);
    chk("wr_new_high", t4 - t3, 100);

    // eff_hp = 1 gives clk/2
    cfg_we = 1'b1; cfg_hp = 24'd1;
    @(negedge clk); cfg_we = 1'b0;
    wait_lvl(1'b1, 500, t1);
    wait_lvl(1'b0, 500, t1);
    wait_lvl(1'b1, 500, t1);
    wait_lvl(1'b0, 500, t2);
    wait_lvl(1'b1, 500, t3);
    chk("hp1_high", t2 - t1, 1);
    chk("hp1_period", t3 - t1, 2);

    // Write and restart in the same cycle
    filter = 2'b01; cfg_we = 1'b1; cfg_sel = 2'b01; cfg_hp = 24'd50; t0 = cyc + 1;
    @(negedge clk); cfg_we = 1'b0;
    wait_lvl(1'b1, 500, t1);
    chk("wr_restart_blue", t1 - t0, 50);
    filter = 2'b11; t0 = cyc + 1;
    wait_lvl(1'b1, 2000, t1);
    chk("green_first_rise", t1 - t0, 600);

    // Saturation: 335545*50 would wrap to 34 in 24 bits
    filter = 2'b00; scale = 2'b01; cfg_we = 1'b1; cfg_sel = 2'b00; cfg_hp = 24'd335545;
    @(negedge clk); cfg_we = 1'b0;
    count_act(5000, hi, rs);
    chk("sat_wrap_high", hi, 0);
    chk("sat_wrap_rises", rs, 0);
    scale = 2'b11; cfg_we = 1'b1; cfg_hp = 24'hFFFFFF;
    @(negedge clk); cfg_we = 1'b0; scale = 2'b01;
    count_act(3000, hi, rs);
    chk("sat_max_rises", rs, 0);

    // Idle conditions
    enf = 1'b0; scale = 2'b11; cfg_we = 1'b1; cfg_hp = 24'd500;
    @(negedge clk); cfg_we = 1'b0;
    count_act(10000, hi, rs);
    chk("idle_enf_high", hi, 0);
    chk("idle_enf_rises", rs, 0);
    enf = 1'b1; scale = 2'b00;
    count_act(10000, hi, rs);
    chk("idle_scale_high", hi, 0);
    chk("idle_scale_rises", rs, 0);
    scale = 2'b11; cfg_we = 1'b1; cfg_sel = 2'b00; cfg_hp = 24'd0;
    @(negedge clk); cfg_we = 1'b0;
    count_act(10000, hi, rs);
    chk("idle_hp0_high", hi, 0);
    chk("idle_hp0_rises", rs, 0);
    cfg_we = 1'b1; cfg_hp = 24'd300; t0 = cyc + 1;
    @(negedge clk); cfg_we = 1'b0;
    wait_lvl(1'b1, 1000, t1);
    chk("hp0_resume", t1 - t0, 300);

    // Asynchronous reset mid-run after a config write
    cfg_we = 1'b1; cfg_hp = 24'd100;
    @(negedge clk); cfg_we = 1'b0;
    wait_lvl(1'b0, 1000, t1);
    wait_lvl(1'b1, 1000, t1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_freq", int'(sensor_freq), 0);
    chk("async_rst_rise", int'(rise_pulse), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; t0 = cyc + 1;
    wait_lvl(1'b1, 2000, t1);
    chk("post_rst_rise", t1 - t0, 500);
    wait_lvl(1'b0, 2000, t2);
    chk("post_rst_high", t2 - t1, 500);
    wait_lvl(1'b1, 2000, t3);
    chk("post_rst_period", t3 - t1, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
